// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the burst-locking round-robin arbiter.
package axi_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Successor index with wrap at n, which need not be a power of two.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/axi_rr_prio_search.sv
// Combinational rotated find-first: the first set request at or after i_ptr, wrapping at N_IN.
module axi_rr_prio_search #(
    parameter int N_IN      = 16,
    parameter int SEL_WIDTH = $clog2(N_IN)
) (
    input  logic [SEL_WIDTH-1:0] i_ptr,
    input  logic [N_IN-1:0]      i_req_valid,
    output logic [SEL_WIDTH-1:0] o_idx,
    output logic                 o_found
);

    logic [SEL_WIDTH:0]   w_sum;
    logic [SEL_WIDTH-1:0] w_cand;

    // Scan from the farthest offset down so that the nearest hit is written last.
    always_comb begin
        o_idx   = i_ptr;
        o_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int unsigned k = N_IN; k > 0; k--) begin
            w_sum  = {1'b0, i_ptr} + (SEL_WIDTH+1)'(k - 1);
            w_cand = (w_sum >= (SEL_WIDTH+1)'(N_IN)) ? SEL_WIDTH'(w_sum - (SEL_WIDTH+1)'(N_IN))
                                                     : SEL_WIDTH'(w_sum);
            if (i_req_valid[w_cand]) begin
                o_idx   = w_cand;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_burst_rr_arbiter.sv
// Round-robin arbiter that holds its grant across a whole burst and across stalls;
// produces the select index for the downstream data multiplexer.
module axi_burst_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int N_IN      = 16,
    parameter int SEL_WIDTH = $clog2(N_IN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_IN-1:0]      req_valid_i,
    input  logic [N_IN-1:0]      req_last_i,
    output logic [N_IN-1:0]      req_ready_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_last_o,
    output logic [SEL_WIDTH-1:0] sel_o,
    output logic [N_IN-1:0]      grant_o
);

    arb_state_t           r_state;
    logic [SEL_WIDTH-1:0] r_ptr;
    logic [SEL_WIDTH-1:0] r_lock_idx;

    logic [SEL_WIDTH-1:0] w_search_idx;
    logic                 w_found;
    logic [SEL_WIDTH-1:0] w_gnt_idx;
    logic                 w_hs;
    logic                 w_done;

    axi_rr_prio_search #(
        .N_IN      (N_IN),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_search (
        .i_ptr       (r_ptr),
        .i_req_valid (req_valid_i),
        .o_idx       (w_search_idx),
        .o_found     (w_found)
    );

    always_comb begin
        if (r_state == ARB_LOCKED) begin
            w_gnt_idx   = r_lock_idx;
            out_valid_o = req_valid_i[r_lock_idx];
        end else begin
            w_gnt_idx   = w_search_idx;
            out_valid_o = w_found;
        end
    end

    assign sel_o       = w_gnt_idx;
    assign out_last_o  = req_last_i[w_gnt_idx] & out_valid_o;
    assign grant_o     = (N_IN'(1) << w_gnt_idx) & {N_IN{out_valid_o}};
    assign req_ready_o = grant_o & {N_IN{out_ready_i}};
    assign w_hs        = out_valid_o & out_ready_i;
    assign w_done      = w_hs & out_last_o;

    // Any valid offer that does not complete a burst (stall or non-last beat) locks the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= '0;
            r_lock_idx <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (out_valid_o && !w_done) begin
                        r_state    <= ARB_LOCKED;
                        r_lock_idx <= w_gnt_idx;
                    end
                end
                ARB_LOCKED: begin
                    if (w_done) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
            if (w_done) begin
                r_ptr <= SEL_WIDTH'(next_idx(32'(w_gnt_idx), N_IN));
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_rr_arbiter.sv
// Directed bench: expected (sel,last) per handshake go to a scoreboard queue that a
// negedge monitor drains; idle/stall/reset states are checked inline.
module tb_axi_burst_rr_arbiter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, rdy4, ov4, ol4;
    logic [3:0] v4, l4, rr4, g4;
    logic [1:0] s4;

    logic       rst5, rdy5, ov5, ol5;
    logic [4:0] v5, l5, rr5, g5;
    logic [2:0] s5;

    int checks   = 0;
    int failures = 0;
    int q4[$];
    int q5[$];

    axi_burst_rr_arbiter #(.N_IN(4)) dut4 (
        .clk(clk), .rst(rst4), .req_valid_i(v4), .req_last_i(l4), .req_ready_o(rr4),
        .out_valid_o(ov4), .out_ready_i(rdy4), .out_last_o(ol4), .sel_o(s4), .grant_o(g4)
    );

    axi_burst_rr_arbiter #(.N_IN(5)) dut5 (
        .clk(clk), .rst(rst5), .req_valid_i(v5), .req_last_i(l5), .req_ready_o(rr5),
        .out_valid_o(ov5), .out_ready_i(rdy5), .out_last_o(ol5), .sel_o(s5), .grant_o(g5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc4(input logic [3:0] v, input logic [3:0] l, input logic r);
        @(posedge clk); #1;
        v4 = v; l4 = l; rdy4 = r;
    endtask

    task automatic cyc5(input logic [4:0] v, input logic [4:0] l, input logic r);
        @(posedge clk); #1;
        v5 = v; l5 = l; rdy5 = r;
    endtask

    // Scoreboard entries encode sel*2 + last.
    always @(negedge clk) begin
        if (!rst4 && ov4 === 1'b1 && rdy4 === 1'b1) begin
            checks++;
            if (q4.size() == 0) begin
                failures++;
                $display("FAIL hs4_unexpected actual_sel=%0d required=none", s4);
            end else begin
                int e;
                e = q4.pop_front();
                if ({30'd0, s4, ol4} !== e) begin
                    failures++;
                    $display("FAIL hs4 actual_sel=%0d last=%0b required_sel=%0d last=%0b",
                             s4, ol4, e / 2, e % 2);
                end
            end
        end
        if (!rst5 && ov5 === 1'b1 && rdy5 === 1'b1) begin
            checks++;
            if (q5.size() == 0) begin
                failures++;
                $display("FAIL hs5_unexpected actual_sel=%0d required=none", s5);
            end else begin
                int e;
                e = q5.pop_front();
                if ({29'd0, s5, ol5} !== e) begin
                    failures++;
                    $display("FAIL hs5 actual_sel=%0d last=%0b required_sel=%0d last=%0b",
                             s5, ol5, e / 2, e % 2);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst4 = 1'b1; v4 = '0; l4 = '0; rdy4 = 1'b0;
        rst5 = 1'b1; v5 = '0; l5 = '0; rdy5 = 1'b0;
        repeat (3) @(negedge clk);
        rst4 = 1'b0; rst5 = 1'b0;
        @(negedge clk);
        chk("reset_sel", 32'(s4), 0);
        chk("reset_valid", 32'(ov4), 0);
        chk("reset_grant", 32'(g4), 0);
        chk("reset_ready", 32'(rr4), 0);

        // 1: all requesting single-beat bursts rotate 0..3 twice
        for (int i = 0; i < 8; i++) begin
            cyc4(4'b1111, 4'b1111, 1'b1);
            q4.push_back((i % 4) * 2 + 1);
            @(negedge clk);
            chk("rot_ready", 32'(rr4), 32'(4'b0001 << (i % 4)));
        end
        cyc4(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        chk("rot_ptr", 32'(s4), 0);
        chk("rot_idle_valid", 32'(ov4), 0);

        // 2: 3-beat burst on input 1 while input 2 waits
        for (int i = 0; i < 3; i++) begin
            cyc4(4'b0110, (i == 2) ? 4'b0010 : 4'b0000, 1'b1);
            q4.push_back(1 * 2 + ((i == 2) ? 1 : 0));
            @(negedge clk);
            chk("burst_ready", 32'(rr4), 32'(4'b0010));
        end
        cyc4(4'b0100, 4'b0100, 1'b1);
        q4.push_back(2 * 2 + 1);
        @(negedge clk);
        cyc4(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        chk("burst_ptr", 32'(s4), 3);

        // 3: stall holds grant on input 0
        for (int i = 0; i < 5; i++) begin
            cyc4(4'b0101, 4'b0101, 1'b0);
            @(negedge clk);
            chk("stall_sel", 32'(s4), 0);
            chk("stall_grant", 32'(g4), 32'(4'b0001));
            chk("stall_ready", 32'(rr4), 0);
        end
        cyc4(4'b0101, 4'b0101, 1'b1);
        q4.push_back(0 * 2 + 1);
        @(negedge clk);
        cyc4(4'b0101, 4'b0101, 1'b1);
        q4.push_back(2 * 2 + 1);
        @(negedge clk);
        cyc4(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        chk("stall_ptr", 32'(s4), 3);

        // 4: locked on 3, it drops valid while input 0 requests
        cyc4(4'b1001, 4'b0000, 1'b1);
        q4.push_back(3 * 2 + 0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            cyc4(4'b0001, 4'b0001, 1'b1);
            @(negedge clk);
            chk("gap_valid", 32'(ov4), 0);
            chk("gap_ready", 32'(rr4), 0);
            chk("gap_sel", 32'(s4), 3);
        end
        cyc4(4'b1001, 4'b1000, 1'b1);
        q4.push_back(3 * 2 + 1);
        @(negedge clk);
        cyc4(4'b0001, 4'b0001, 1'b1);
        q4.push_back(0 * 2 + 1);
        @(negedge clk);
        cyc4(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        chk("gap_ptr", 32'(s4), 1);

        // 6: async reset while locked on 2 with ptr=3
        cyc4(4'b0100, 4'b0100, 1'b1);
        q4.push_back(2 * 2 + 1);
        @(negedge clk);
        cyc4(4'b0100, 4'b0000, 1'b1);
        q4.push_back(2 * 2 + 0);
        @(negedge clk);
        cyc4(4'b0110, 4'b0110, 1'b0);
        #2;
        chk("prerst_locked_sel", 32'(s4), 2);
        rst4 = 1'b1;
        #1;
        chk("rst_async_sel", 32'(s4), 1);
        chk("rst_async_grant", 32'(g4), 32'(4'b0010));
        @(negedge clk);
        #1 rst4 = 1'b0;
        cyc4(4'b0110, 4'b0110, 1'b1);
        q4.push_back(1 * 2 + 1);
        @(negedge clk);
        cyc4(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        chk("rst_ptr", 32'(s4), 2);

        // 5: N_IN=5 wrap from 4 to 0
        cyc5(5'b01000, 5'b01000, 1'b1);
        q5.push_back(3 * 2 + 1);
        @(negedge clk);
        cyc5(5'b00000, 5'b00000, 1'b1);
        @(negedge clk);
        chk("n5_ptr4", 32'(s5), 4);
        cyc5(5'b10001, 5'b10001, 1'b1);
        q5.push_back(4 * 2 + 1);
        @(negedge clk);
        cyc5(5'b00000, 5'b00000, 1'b1);
        @(negedge clk);
        chk("n5_ptr_wrap", 32'(s5), 0);
        cyc5(5'b00001, 5'b00001, 1'b1);
        q5.push_back(0 * 2 + 1);
        @(negedge clk);
        cyc5(5'b00000, 5'b00000, 1'b1);
        @(negedge clk);
        chk("n5_ptr1", 32'(s5), 1);

        repeat (2) @(negedge clk);
        chk("q4_drained", 32'(q4.size()), 0);
        chk("q5_drained", 32'(q5.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
